sound_mixer: RTL and testbench
==============================

// Module: sound_mixer
//
// PURPOSE
//   Multi-channel PCM mixer feeding the 1-bit DAC (SOUND_IF producer side).
//   On each sample strobe it snapshots all channel samples, then serially
//   multiply-accumulates them with per-channel volume over CH_COUNT cycles.
//   It then scales, saturates and presents one signed sample with a valid pulse.
//   One instance each drives the internal (cartridge) and external sound DACs.
//
// PARAMETERS
//   CH_COUNT   4   number of input channels (>=1)
//   IN_WIDTH   16  signed sample width per channel
//   VOL_WIDTH  4   unsigned volume width; gain = vol / 2**VOL_WIDTH
//   OUT_WIDTH  16  signed output sample width (<= IN_WIDTH+VOL_WIDTH)
//
// PORTS
//   CLK        in   1                    system clock (108 MHz)
//   RESET      in   1                    synchronous reset, active-high
//   SAMPLE_EN  in   1                    sample strobe, 1-cycle pulse (e.g. 3.58 MHz tick)
//   CH_IN      in   CH_COUNT*IN_WIDTH    signed samples, ch0 in LSBs
//   CH_VOL     in   CH_COUNT*VOL_WIDTH   unsigned volumes, ch0 in LSBs
//   CH_MUTE    in   CH_COUNT             1 = channel contributes 0
//   OUT        out  OUT_WIDTH            signed mixed sample, held between updates
//   OUT_VALID  out  1                    1-cycle pulse when OUT updates
//   CLIP       out  1                    OUT of latest sample was saturated; valid with OUT
//   BUSY       out  1                    mix in progress; SAMPLE_EN ignored
//   DROP       out  1                    1-cycle pulse: SAMPLE_EN arrived while BUSY
//
// BEHAVIOUR
//   Reset: OUT=0, OUT_VALID=0, CLIP=0, BUSY=0, DROP=0, acc=0, state=IDLE.
//     Reset mid-mix aborts; no OUT_VALID is produced for the aborted sample.
//   FSM: IDLE -> ACCUM -> DONE -> IDLE.
//   IDLE: SAMPLE_EN=1 at cycle t -> CH_IN/CH_VOL/CH_MUTE copied to snapshot regs.
//     Also acc=0, idx=0, go to ACCUM. Input changes after t do not affect this sample.
//   ACCUM: one channel per cycle, idx 0..CH_COUNT-1.
//     acc += mute[idx] ? 0 : sample[idx] * $signed({1'b0,vol[idx]}).
//     Leave after idx = CH_COUNT-1.
//     Product width IN_WIDTH+VOL_WIDTH+1.
//     acc width IN_WIDTH+VOL_WIDTH+1+$clog2(CH_COUNT); it never overflows.
//   DONE: scaled = acc >>> VOL_WIDTH (arithmetic, rounds toward -inf).
//     Saturate to [-2**(OUT_WIDTH-1), 2**(OUT_WIDTH-1)-1], register into OUT.
//     CLIP = saturation occurred. Return to IDLE.
//   OUT_VALID is high exactly in cycle t+CH_COUNT+2, with the new OUT/CLIP visible.
//   BUSY is high from t+1 through t+CH_COUNT+2 inclusive.
//   Next SAMPLE_EN is accepted at t+CH_COUNT+3 or later.
//   SAMPLE_EN while BUSY: ignored and DROP pulses the following cycle.
//     The in-progress mix completes unaffected.
//   SAMPLE_EN held high for multiple cycles: each high cycle is a strobe.
//     The first is accepted; those during BUSY cause DROP.
//   vol=0 or mute: channel contributes exactly 0.
//   Max gain is (2**VOL_WIDTH-1)/2**VOL_WIDTH, which is 15/16 at the defaults.
//
// TESTING (defaults: CH_COUNT=4, IN_WIDTH=16, VOL_WIDTH=4, OUT_WIDTH=16)
//   1. ch0=1000, vol0=8, others muted; SAMPLE_EN at t.
//      -> OUT=500, CLIP=0, OUT_VALID only at t+6, BUSY t+1..t+6.
//   2. ch0=-1000, vol0=8 -> OUT=-500. ch0=-1, vol0=1 -> OUT=-1 (floor rounding).
//   3. All ch=16384, vol=15, no mute.
//      -> acc=983040, OUT=32767, CLIP=1. All ch=-32768, vol=15 -> OUT=-32768, CLIP=1.
//   4. SAMPLE_EN at t and t+3.
//      -> DROP at t+4, single OUT_VALID at t+6. Inputs changed at t+1 do not affect OUT.
//   5. RESET asserted at t+3 of a mix.
//      -> OUT=0, BUSY=0, no OUT_VALID; a new SAMPLE_EN after reset mixes normally.
//   6. Back-to-back SAMPLE_EN every 7 cycles for 100 samples, random data.
//      -> no DROP; OUT matches the reference model for every sample.

Source files
------------

// File: rtl/sound_mixer.sv
// sound_mixer: multi-channel PCM mixer for the 1-bit sound DAC.
//
// On an accepted sample strobe all channel samples, volumes and mutes are
// snapshotted.  Each channel is then multiply-accumulated with its volume,
// one per cycle.  The sum is scaled by 2**-VOL_WIDTH, saturated and
// presented on out with a one-cycle out_valid pulse.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous reset, active-high
//   sample_en  in   sample strobe; every high cycle counts as one strobe
//   ch_in      in   CH_COUNT signed samples, ch0 in the LSBs
//   ch_vol     in   CH_COUNT unsigned volumes, ch0 in the LSBs
//   ch_mute    in   per-channel mute, 1 = channel contributes 0
//   out        out  signed mixed sample, held between updates
//   out_valid  out  one-cycle pulse when out updates
//   clip       out  latest out was saturated; valid alongside out
//   busy       out  mix in progress; strobes are ignored while high
//   drop       out  one-cycle pulse, the cycle after a strobe hit busy
//   mix_state  out  current FSM state (debug)
//
// Handshake: a strobe is taken only in a cycle where busy is low.  busy
// rises the next cycle and stays high through the out_valid cycle, so a
// strobe in the cycle right after out_valid is the earliest one accepted.
module sound_mixer #(
    parameter int CH_COUNT  = 4,
    parameter int IN_WIDTH  = 16,
    parameter int VOL_WIDTH = 4,
    parameter int OUT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_en,
    input  logic [CH_COUNT*IN_WIDTH-1:0]  ch_in,
    input  logic [CH_COUNT*VOL_WIDTH-1:0] ch_vol,
    input  logic [CH_COUNT-1:0]           ch_mute,
    output logic [OUT_WIDTH-1:0]          out,
    output logic                          out_valid,
    output logic                          clip,
    output logic                          busy,
    output logic                          drop,
    output logic [1:0]                    mix_state
);

    localparam int PROD_W = IN_WIDTH + VOL_WIDTH + 1;
    localparam int ACC_W  = PROD_W + $clog2(CH_COUNT);
    localparam int IDX_W  = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;

    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = -OUT_MAX - ACC_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                        state;
    logic [CH_COUNT*IN_WIDTH-1:0]  snap_in;
    logic [CH_COUNT*VOL_WIDTH-1:0] snap_vol;
    logic [CH_COUNT-1:0]           snap_mute;
    logic [IDX_W-1:0]              idx;
    logic signed [ACC_W-1:0]       acc;

    logic [IN_WIDTH-1:0]           sample_sel;
    logic [VOL_WIDTH-1:0]          vol_sel;
    logic                          mute_sel;
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_W-1:0]       term;
    logic signed [ACC_W-1:0]       scaled;
    logic [OUT_WIDTH-1:0]          sat_val;
    logic                          sat_flag;

    assign mix_state = state;

    // Multiply the selected channel.  Both operands are extended to the
    // full product width first (sample sign-extended, volume zero-extended)
    // so the truncated product is exact.
    always_comb begin
        sample_sel = snap_in[idx*IN_WIDTH +: IN_WIDTH];
        vol_sel    = snap_vol[idx*VOL_WIDTH +: VOL_WIDTH];
        mute_sel   = snap_mute[idx];
        prod       = $signed({{(VOL_WIDTH+1){sample_sel[IN_WIDTH-1]}}, sample_sel})
                   * $signed({{(IN_WIDTH+1){1'b0}}, vol_sel});
        term       = mute_sel ? '0
                              : $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
    end

    // Arithmetic shift floors toward -inf, then clamp into the output range.
    always_comb begin
        scaled   = acc >>> VOL_WIDTH;
        sat_flag = 1'b0;
        sat_val  = scaled[OUT_WIDTH-1:0];
        if (scaled > OUT_MAX) begin
            sat_val  = OUT_MAX[OUT_WIDTH-1:0];
            sat_flag = 1'b1;
        end else if (scaled < OUT_MIN) begin
            sat_val  = OUT_MIN[OUT_WIDTH-1:0];
            sat_flag = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            snap_in   <= '0;
            snap_vol  <= '0;
            snap_mute <= '0;
            idx       <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            clip      <= 1'b0;
            busy      <= 1'b0;
            drop      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            drop      <= sample_en && busy;
            case (state)
                IDLE: begin
                    // busy can still be high here: that is the out_valid cycle.
                    busy <= 1'b0;
                    if (sample_en && !busy) begin
                        snap_in   <= ch_in;
                        snap_vol  <= ch_vol;
                        snap_mute <= ch_mute;
                        acc       <= '0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + term;
                    idx <= idx + IDX_W'(1);
                    if (idx == IDX_W'(CH_COUNT - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    out       <= sat_val;
                    clip      <= sat_flag;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sound_mixer.sv
module tb_sound_mixer;

    localparam int CH  = 4;
    localparam int IW  = 16;
    localparam int VW  = 4;
    localparam int OW  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              sample_en;
    logic [CH*IW-1:0]  ch_in;
    logic [CH*VW-1:0]  ch_vol;
    logic [CH-1:0]     ch_mute;
    logic [OW-1:0]     out;
    logic              out_valid;
    logic              clip;
    logic              busy;
    logic              drop;
    logic [1:0]        mix_state;

    int tests = 0;
    int fails = 0;
    int valid_cnt = 0;
    int drop_cnt = 0;

    logic [OW-1:0] exp_q[$];
    logic          exp_clip_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    sound_mixer #(.CH_COUNT(CH), .IN_WIDTH(IW), .VOL_WIDTH(VW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en),
        .ch_in(ch_in), .ch_vol(ch_vol), .ch_mute(ch_mute),
        .out(out), .out_valid(out_valid), .clip(clip),
        .busy(busy), .drop(drop), .mix_state(mix_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Reference: sum of sample*vol over unmuted channels, floor-divide by
    // 2**VW, clamp to the signed output range.
    task automatic push_model(input int s[CH], input int v[CH], input logic [CH-1:0] m);
        longint sum = 0;
        longint q;
        logic   c = 1'b0;
        for (int i = 0; i < CH; i++)
            if (!m[i]) sum += longint'(s[i]) * longint'(v[i]);
        q = sum >>> VW;
        if (q > 32767) begin q = 32767; c = 1'b1; end
        if (q < -32768) begin q = -32768; c = 1'b1; end
        exp_q.push_back(q[OW-1:0]);
        exp_clip_q.push_back(c);
    endtask

    // Scoreboard: every out_valid pops one expectation.
    always @(negedge clk) begin
        if (drop) drop_cnt++;
        if (out_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                check("out",  {{16{out[OW-1]}}, out}, {{16{exp_q[0][OW-1]}}, exp_q[0]});
                check("clip", 32'(clip), 32'(exp_clip_q[0]));
                void'(exp_q.pop_front());
                void'(exp_clip_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s[CH], input int v[CH], input logic [CH-1:0] m);
        for (int i = 0; i < CH; i++) begin
            ch_in[i*IW +: IW]  = IW'(s[i]);
            ch_vol[i*VW +: VW] = VW'(v[i]);
        end
        ch_mute = m;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        @(negedge clk);
        check(tag, 32'(exp_q.size()), 32'd0);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s[CH];
        int v[CH];
        int vc;
        int dc;

        reset = 1'b1; sample_en = 1'b0; ch_in = '0; ch_vol = '0; ch_mute = '0;
        step(); step();
        @(negedge clk);
        check("rst_out", 32'(out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clip", 32'(clip), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        step();
        reset = 1'b0;
        step();

        // 1: single channel at half gain, with cycle-accurate timing.
        s = '{1000, 0, 0, 0}; v = '{8, 0, 0, 0};
        drive(s, v, 4'b1110);
        push_model(s, v, 4'b1110);
        sample_en = 1'b1;                       // cycle t
        for (int n = 1; n <= 7; n++) begin
            step();
            sample_en = 1'b0;
            @(negedge clk);
            check($sformatf("t1_valid_t%0d", n), 32'(out_valid), 32'(n == 6));
            check($sformatf("t1_busy_t%0d", n), 32'(busy), 32'(n <= 6));
        end
        check("t1_out_const", {{16{out[OW-1]}}, out}, 32'd500);
        step();

        // 2: negative values and floor rounding.
        s = '{-1000, 0, 0, 0}; v = '{8, 0, 0, 0};
        drive(s, v, 4'b1110); push_model(s, v, 4'b1110);
        sample_en = 1'b1; step(); sample_en = 1'b0;
        wait_drain("t2a_drain");
        s = '{-1, 0, 0, 0}; v = '{1, 0, 0, 0};
        drive(s, v, 4'b1110); push_model(s, v, 4'b1110);
        sample_en = 1'b1; step(); sample_en = 1'b0;
        wait_drain("t2b_drain");
        check("t2b_out_const", {{16{out[OW-1]}}, out}, 32'hFFFF_FFFF);

        // 3: saturation both ways.
        s = '{16384, 16384, 16384, 16384}; v = '{15, 15, 15, 15};
        drive(s, v, 4'b0000); push_model(s, v, 4'b0000);
        sample_en = 1'b1; step(); sample_en = 1'b0;
        wait_drain("t3a_drain");
        check("t3a_out_const", 32'(out), 32'd32767);
        check("t3a_clip_const", 32'(clip), 32'd1);
        s = '{-32768, -32768, -32768, -32768};
        drive(s, v, 4'b0000); push_model(s, v, 4'b0000);
        sample_en = 1'b1; step(); sample_en = 1'b0;
        wait_drain("t3b_drain");
        check("t3b_out_const", 32'(out), 32'h8000);

        // 4: strobe during busy is dropped; input changes after t ignored.
        vc = valid_cnt; dc = drop_cnt;
        s = '{1000, 0, 0, 0}; v = '{8, 0, 0, 0};
        drive(s, v, 4'b1110); push_model(s, v, 4'b1110);
        sample_en = 1'b1;                       // t
        step(); sample_en = 1'b0;               // t+1
        s = '{-20000, 5000, 7000, 9000}; v = '{15, 15, 15, 15};
        drive(s, v, 4'b0000);
        step(); step();                         // t+3
        sample_en = 1'b1;
        step(); sample_en = 1'b0;               // t+4
        @(negedge clk);
        check("t4_drop_t4", 32'(drop), 32'd1);
        step();                                 // t+5
        @(negedge clk);
        check("t4_drop_t5", 32'(drop), 32'd0);
        wait_drain("t4_drain");
        step(); step();
        check("t4_single_valid", 32'(valid_cnt - vc), 32'd1);
        check("t4_drop_count", 32'(drop_cnt - dc), 32'd1);

        // 5: reset mid-mix aborts; next strobe mixes normally.
        check("t5_pre_out_nonzero", 32'(out == 0), 32'd0);
        vc = valid_cnt;
        s = '{3000, 3000, 0, 0}; v = '{15, 15, 0, 0};
        drive(s, v, 4'b0000);
        sample_en = 1'b1;                       // t
        step(); sample_en = 1'b0;
        step(); step();                         // t+3
        reset = 1'b1;
        step(); reset = 1'b0;                   // t+4
        @(negedge clk);
        check("t5_out", 32'(out), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        for (int n = 0; n < 8; n++) step();
        check("t5_no_valid", 32'(valid_cnt - vc), 32'd0);
        push_model(s, v, 4'b0000);
        sample_en = 1'b1; step(); sample_en = 1'b0;
        wait_drain("t5_drain");

        // 6: back-to-back strobes every 7 cycles with random data.
        dc = drop_cnt;
        for (int k = 0; k < 100; k++) begin
            logic [CH-1:0] m;
            for (int i = 0; i < CH; i++) begin
                s[i] = $signed(16'($urandom_range(0, 65535)));
                v[i] = int'($urandom_range(0, 15));
            end
            m = 4'($urandom_range(0, 15));
            drive(s, v, m); push_model(s, v, m);
            sample_en = 1'b1;
            step(); sample_en = 1'b0;
            for (int n = 0; n < 6; n++) step();
        end
        wait_drain("t6_drain");
        check("t6_no_drop", 32'(drop_cnt - dc), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
